sample_window8: RTL and testbench
=================================

Name: sample_window8

Overview:
- Streaming front-end that collects unsigned sensor samples into an 8-deep window.
- Presents the window as eight parallel words, directly feeding the 8-input min/max comparator stage.
- Two modes:
  - block: non-overlapping windows, one every 8 samples.
  - sliding: one window per new sample once the window is full.
- Valid/ready handshakes on both sides; the window is held stable under backpressure.

Parameters:
- BIT_WIDTH, 16, width of each sample and of each window word.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = block, 1 = sliding.
- clear  input  1  synchronous flush of window state.
- in_valid  input  1  upstream sample valid.
- in_data  input  BIT_WIDTH  upstream sample.
- in_ready  output  1  block can accept a sample this cycle.
- out_valid  output  1  window data0..data7 is complete and stable.
- out_ready  input  1  downstream consumes the window.
- data0..data7  output  BIT_WIDTH each  window words; data0 is the oldest sample, data7 the newest.
- fill_count  output  4  number of samples currently held, 0..8.

Behaviour:
- Reset (rst=1): data0..data7=0, fill_count=0, out_valid=0, mode_q=0, and in_ready=0 while rst is high. Reset aborts any partial fill.
- Accept event: in_valid && in_ready. On accept:
  - data7<=in_data and data(k)<=data(k+1) for k=0..6.
  - fill_count<=min(fill_count+1, 8); saturates at 8 and never wraps.
- Output event: out_valid && out_ready.
- Latency: the window containing a sample is visible, with out_valid=1, in the cycle after that sample's accept edge.
- Block mode (mode_q=0):
  - in_ready = !out_valid.
  - The accept that brings fill_count to 8 sets out_valid=1.
  - On the output event: out_valid<=0, fill_count<=0. Data registers keep their old values; they are overwritten by the next 8 samples.
  - No sample is accepted while a window is pending.
- Sliding mode (mode_q=1):
  - in_ready = !out_valid || out_ready.
  - After any accept leaving fill_count==8: out_valid<=1.
  - Output event with no accept: out_valid<=0; fill_count stays 8.
  - Output event with a simultaneous accept: window shifts and out_valid stays 1, giving full throughput of one window per cycle.
- Stall: while out_valid=1 and out_ready=0, data0..data7 and fill_count do not change.
- clear=1 (priority below rst, above everything else):
  - fill_count<=0, out_valid<=0, data0..data7<=0.
  - in_ready=0 that cycle; an in_valid sample is dropped, not accepted.
- Mode change: mode is registered into mode_q every cycle. If mode != mode_q, the cycle behaves exactly as clear=1; the new mode is effective the following cycle.
- in_ready is combinational from registered state, rst, clear, mode/mode_q and out_ready only. It never depends on in_valid.

Decomposition:
- Shared header/package:
  - localparam WIN_DEPTH=8.
  - localparam MODE_BLOCK=1'b0 and MODE_SLIDE=1'b1.
  - fill_count width (4).
- No sub-module: the shift register, counter and valid flag are one small always block set.
- Downstream min/max is instantiated by the parent, not inside this block.

Test Plan:
- Block mode: feed 1..8 back-to-back with out_ready=1 -> out_valid=1 for one cycle after the 8th accept, data0=1..data7=8, fill_count=8, then 0; in_ready=0 in that cycle.
- Block backpressure: fill 8 samples with out_ready=0 for 5 cycles, in_valid held high with 9 -> window stays 1..8, in_ready=0; after out_ready=1, sample 9 is accepted next and fill_count=1.
- Sliding mode: feed 10..19 continuously with out_ready=1 -> out_valid rises after the 8th accept; windows are 10..17, 11..18, 12..19 on consecutive cycles.
- Sliding stall: full window, out_ready=0, in_valid=1 -> no shift, in_ready=0; release -> shift and out_valid stays 1 in the same cycle.
- Clear mid-fill: accept 5 samples, assert clear with in_valid=1 -> fill_count=0, data words=0, out_valid=0, and the sample presented during clear is absent from the next window.
- Reset/mode change: toggle mode with fill_count=6, then assert rst after 3 accepts -> fill_count=0 in both cases, all outputs 0 after rst, in_ready=0 while rst is high.

Source files
------------

// File: rtl/sample_window8_pkg.sv
// Shared constants and types for the sample_window8 streaming window front-end.
package sample_window8_pkg;
  localparam int WIN_DEPTH = 8;
  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_SLIDE = 1'b1;
  localparam int FILL_W = 4;

  typedef logic [FILL_W-1:0] fill_t;

  localparam fill_t FILL_FULL = fill_t'(WIN_DEPTH);
endpackage

// File: rtl/sample_window8.sv
// Collects unsigned samples into an 8-deep shift window, emitted either as
// non-overlapping blocks or as a sliding window with valid/ready on both sides.
module sample_window8
  import sample_window8_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] data0,
  output logic [BIT_WIDTH-1:0] data1,
  output logic [BIT_WIDTH-1:0] data2,
  output logic [BIT_WIDTH-1:0] data3,
  output logic [BIT_WIDTH-1:0] data4,
  output logic [BIT_WIDTH-1:0] data5,
  output logic [BIT_WIDTH-1:0] data6,
  output logic [BIT_WIDTH-1:0] data7,
  output logic [FILL_W-1:0]    fill_count
);

  logic [BIT_WIDTH-1:0] r_win [WIN_DEPTH];
  fill_t                r_fill;
  logic                 r_out_valid;
  logic                 r_mode_q;

  logic  w_flush;
  logic  w_accept;
  logic  w_out_evt;
  fill_t w_fill_inc;

  function automatic fill_t sat_inc(input fill_t f);
    return (f >= FILL_FULL) ? FILL_FULL : f + fill_t'(1);
  endfunction

  // A mode switch behaves as a flush so no window ever mixes the two modes.
  assign w_flush    = clear || (mode != r_mode_q);
  assign w_fill_inc = sat_inc(r_fill);
  assign w_out_evt  = r_out_valid && out_ready;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst && !w_flush) begin
      if (r_mode_q == MODE_SLIDE) in_ready = !r_out_valid || out_ready;
      else                        in_ready = !r_out_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q    <= MODE_BLOCK;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < WIN_DEPTH; k++) r_win[k] <= '0;
    end else begin
      r_mode_q <= mode;
      if (w_flush) begin
        r_fill      <= '0;
        r_out_valid <= 1'b0;
        for (int k = 0; k < WIN_DEPTH; k++) r_win[k] <= '0;
      end else if (w_accept) begin
        for (int k = 0; k < WIN_DEPTH - 1; k++) r_win[k] <= r_win[k+1];
        r_win[WIN_DEPTH-1] <= in_data;
        r_fill             <= w_fill_inc;
        r_out_valid        <= (w_fill_inc == FILL_FULL);
      end else if (w_out_evt) begin
        // Block mode restarts the count; the old words linger until overwritten.
        r_out_valid <= 1'b0;
        if (r_mode_q == MODE_BLOCK) r_fill <= '0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign fill_count = r_fill;
  assign data0 = r_win[0];
  assign data1 = r_win[1];
  assign data2 = r_win[2];
  assign data3 = r_win[3];
  assign data4 = r_win[4];
  assign data5 = r_win[5];
  assign data6 = r_win[6];
  assign data7 = r_win[7];

endmodule

// File: tb/tb_sample_window8.sv
// Directed self-checking bench for sample_window8: block, sliding, stall,
// clear, mode change and reset scenarios with hand-computed windows.
module tb_sample_window8;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data0, data1, data2, data3, data4, data5, data6, data7;
  logic [3:0]   fill_count;
  logic [W-1:0] d [8];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign d[0] = data0; assign d[1] = data1; assign d[2] = data2; assign d[3] = data3;
  assign d[4] = data4; assign d[5] = data5; assign d[6] = data6; assign d[7] = data7;

  sample_window8 #(.BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .fill_count(fill_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b1;
    cyc(); cyc();
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    n_cmp++;
    if (fill_count !== 4'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (d[k] !== '0) begin n_fail++; $display("FAIL reset_data%0d got=%0d exp=0", k, d[k]); end
    end
    in_valid = 1'b0; rst = 1'b0;
    cyc();
  endtask

  task automatic test_block();
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1'b1; in_data = W'(v);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL block_in_ready s%0d got=%0b exp=1", v, in_ready); end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL block_out_valid got=%0b exp=1", out_valid); end
    n_cmp++;
    if (fill_count !== 4'd8) begin n_fail++; $display("FAIL block_fill got=%0d exp=8", fill_count); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL block_in_ready_full got=%0b exp=0", in_ready); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (d[k] !== W'(k + 1)) begin n_fail++; $display("FAIL block_data%0d got=%0d exp=%0d", k, d[k], k + 1); end
    end
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL block_out_valid_drop got=%0b exp=0", out_valid); end
    n_cmp++;
    if (fill_count !== 4'd0) begin n_fail++; $display("FAIL block_fill_reset got=%0d exp=0", fill_count); end
  endtask

  task automatic test_block_backpressure();
    out_ready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1'b1; in_data = W'(v);
      cyc();
    end
    in_data = 16'd9;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d got=%0b exp=0", c, in_ready); end
      n_cmp++;
      if (out_valid !== 1'b1 || data0 !== 16'd1 || data7 !== 16'd8 || fill_count !== 4'd8) begin
        n_fail++;
        $display("FAIL bp_hold c%0d got v=%0b d0=%0d d7=%0d f=%0d exp v=1 d0=1 d7=8 f=8",
                 c, out_valid, data0, data7, fill_count);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 4'd1 || data7 !== 16'd9) begin
      n_fail++; $display("FAIL bp_next_sample got f=%0d d7=%0d exp f=1 d7=9", fill_count, data7);
    end
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_sliding();
    mode = 1'b1; out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = W'(10 + i);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL slide_in_ready i%0d got=%0b exp=1", i, in_ready); end
      cyc();
      n_cmp++;
      if (out_valid !== (i >= 7)) begin n_fail++; $display("FAIL slide_out_valid i%0d got=%0b exp=%0b", i, out_valid, i >= 7); end
      if (i >= 7) begin
        for (int k = 0; k < 8; k++) begin
          n_cmp++;
          if (d[k] !== W'(3 + i + k)) begin n_fail++; $display("FAIL slide_data i%0d k%0d got=%0d exp=%0d", i, k, d[k], 3 + i + k); end
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0 || fill_count !== 4'd8) begin
      n_fail++; $display("FAIL slide_drain got v=%0b f=%0d exp v=0 f=8", out_valid, fill_count);
    end
  endtask

  task automatic test_sliding_stall();
    in_valid = 1'b1; in_data = 16'd20;
    cyc();
    out_ready = 1'b0; in_data = 16'd21;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d got=%0b exp=0", c, in_ready); end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || data0 !== 16'd13 || data7 !== 16'd20 || fill_count !== 4'd8) begin
        n_fail++;
        $display("FAIL stall_hold c%0d got v=%0b d0=%0d d7=%0d f=%0d exp v=1 d0=13 d7=20 f=8",
                 c, out_valid, data0, data7, fill_count);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_rdy got=%0b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || data0 !== 16'd14 || data7 !== 16'd21) begin
      n_fail++; $display("FAIL stall_release got v=%0b d0=%0d d7=%0d exp v=1 d0=14 d7=21", out_valid, data0, data7);
    end
    cyc();
  endtask

  task automatic test_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int v = 31; v <= 35; v++) begin
      in_valid = 1'b1; in_data = W'(v);
      cyc();
    end
    n_cmp++;
    if (fill_count !== 4'd5) begin n_fail++; $display("FAIL clear_prefill got=%0d exp=5", fill_count); end
    clear = 1'b1; in_data = 16'd99;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready got=%0b exp=0", in_ready); end
    cyc();
    clear = 1'b0;
    n_cmp++;
    if (fill_count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_state got f=%0d v=%0b exp f=0 v=0", fill_count, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (d[k] !== '0) begin n_fail++; $display("FAIL clear_data%0d got=%0d exp=0", k, d[k]); end
    end
    for (int v = 41; v <= 48; v++) begin
      in_valid = 1'b1; in_data = W'(v);
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (d[k] !== W'(41 + k)) begin n_fail++; $display("FAIL clear_refill_data%0d got=%0d exp=%0d", k, d[k], 41 + k); end
    end
    cyc();
  endtask

  task automatic test_mode_and_reset();
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      in_valid = 1'b1; in_data = W'(v);
      cyc();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 4'd6) begin n_fail++; $display("FAIL mode_prefill got=%0d exp=6", fill_count); end
    mode = 1'b0; in_valid = 1'b1; in_data = 16'd77;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mode_switch_rdy got=%0b exp=0", in_ready); end
    cyc();
    in_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 4'd0 || out_valid !== 1'b0 || data7 !== '0) begin
      n_fail++; $display("FAIL mode_switch got f=%0d v=%0b d7=%0d exp f=0 v=0 d7=0", fill_count, out_valid, data7);
    end
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1; in_data = W'(v + 60);
      cyc();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 4'd3 || data7 !== 16'd63) begin
      n_fail++; $display("FAIL mode_new_block got f=%0d d7=%0d exp f=3 d7=63", fill_count, data7);
    end
    rst = 1'b1; in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    cyc();
    n_cmp++;
    if (fill_count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_state got f=%0d v=%0b exp f=0 v=0", fill_count, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (d[k] !== '0) begin n_fail++; $display("FAIL rst_data%0d got=%0d exp=0", k, d[k]); end
    end
    rst = 1'b0; in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_block();
    test_block_backpressure();
    test_sliding();
    test_sliding_stall();
    test_clear();
    test_mode_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
